// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer with press/release edge pulses and per-channel auto-repeat.
// Each channel is synchronised, polarity-normalised, debounced and fed to its own repeat FSM.
module key_debounce_multi #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic [NUM_KEYS-1:0] iKey,
   input  logic [NUM_KEYS-1:0] iRepeatEn,
   output logic [NUM_KEYS-1:0] oLevel,
   output logic [NUM_KEYS-1:0] oPress,
   output logic [NUM_KEYS-1:0] oRelease,
   output logic [NUM_KEYS-1:0] oRepeat
);

   localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RP_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);
   // Level a raw key shows when nobody is pressing it.
   localparam logic            REL_LVL    = (ACTIVE_LOW != 32'sd0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      RPT   = 2'd2
   } rptState_t;

   genvar g;
   generate
      for (g = 0; g < NUM_KEYS; g++) begin : gChan
         logic            metaR;
         logic            syncR;
         logic            keyS;
         logic            diffS;
         logic            acceptS;
         logic            levelR;
         logic            pressR;
         logic            releaseR;
         logic            repeatR;
         logic [DB_W-1:0] dbCntR;
         logic [RP_W-1:0] rpCntR;
         rptState_t       stateR;

         // Two-flop synchroniser, preloaded with the released level.
         always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
               metaR <= REL_LVL;
               syncR <= REL_LVL;
            end else begin
               metaR <= iKey[g];
               syncR <= metaR;
            end
         end

         // Normalise polarity and detect the edge on which a change is accepted.
         always_comb begin
            keyS    = syncR ^ REL_LVL;
            diffS   = keyS ^ levelR;
            acceptS = diffS && (dbCntR == DB_LAST);
         end

         // Debounce counter, debounced level and press/release pulses.
         always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
               dbCntR   <= '0;
               levelR   <= 1'b0;
               pressR   <= 1'b0;
               releaseR <= 1'b0;
            end else begin
               pressR   <= acceptS & keyS;
               releaseR <= acceptS & ~keyS;
               if (!diffS || acceptS) begin
                  dbCntR <= '0;
               end else begin
                  dbCntR <= dbCntR + DB_W'(1);
               end
               if (acceptS) begin
                  levelR <= keyS;
               end else begin
                  levelR <= levelR;
               end
            end
         end

         // Auto-repeat FSM; a release or disable wins over any pending pulse.
         always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
               stateR  <= IDLE;
               rpCntR  <= '0;
               repeatR <= 1'b0;
            end else if (!iRepeatEn[g] || (acceptS && !keyS)) begin
               stateR  <= IDLE;
               rpCntR  <= '0;
               repeatR <= 1'b0;
            end else begin
               case (stateR)
                  IDLE: begin
                     rpCntR  <= '0;
                     repeatR <= 1'b0;
                     stateR  <= (acceptS && keyS) ? DELAY : IDLE;
                  end
                  DELAY: begin
                     if (rpCntR == DELAY_LAST) begin
                        rpCntR  <= '0;
                        repeatR <= 1'b1;
                        stateR  <= RPT;
                     end else begin
                        rpCntR  <= rpCntR + RP_W'(1);
                        repeatR <= 1'b0;
                        stateR  <= DELAY;
                     end
                  end
                  RPT: begin
                     if (rpCntR == RATE_LAST) begin
                        rpCntR  <= '0;
                        repeatR <= 1'b1;
                     end else begin
                        rpCntR  <= rpCntR + RP_W'(1);
                        repeatR <= 1'b0;
                     end
                     stateR <= RPT;
                  end
                  default: begin
                     stateR  <= IDLE;
                     rpCntR  <= '0;
                     repeatR <= 1'b0;
                  end
               endcase
            end
         end

         assign oLevel[g]   = levelR;
         assign oPress[g]   = pressR;
         assign oRelease[g] = releaseR;
         assign oRepeat[g]  = repeatR;
      end
   endgenerate

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_key_debounce_multi;

   logic       clk = 1'b0;
   logic       rstN = 1'b1;
   logic [1:0] key = 2'b11;
   logic [1:0] rptEn = 2'b00;
   logic [1:0] lvl, prs, rel, rpt;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   bit         monOn = 1'b0;

   typedef struct {
      int         cyc;
      logic [1:0] lvl;
      logic [1:0] prs;
      logic [1:0] rel;
      logic [1:0] rpt;
   } exp_t;

   exp_t q[$];
   exp_t monE;

   key_debounce_multi #(
      .NUM_KEYS(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .ACTIVE_LOW(1)
   ) dut (
      .iCLK(clk), .iRST_N(rstN), .iKey(key), .iRepeatEn(rptEn),
      .oLevel(lvl), .oPress(prs), .oRelease(rel), .oRepeat(rpt)
   );

   always #5 clk = ~clk;

   // Edge counter: at the negedge after edge n it reads n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   task automatic push(input int c, input logic [1:0] l, input logic [1:0] p,
                       input logic [1:0] r, input logic [1:0] t);
      exp_t e;
      e.cyc = c; e.lvl = l; e.prs = p; e.rel = r; e.rpt = t;
      q.push_back(e);
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every pulse must match the head of the queue; a due entry with no pulse is a miss.
   always @(negedge clk) begin
      if (monOn) begin
         if (|{prs, rel, rpt}) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse at cycle %0d: press=%b release=%b repeat=%b, expected none",
                        cyc, prs, rel, rpt);
            end else begin
               monE = q.pop_front();
               check("pulse_cycle", cyc, monE.cyc);
               check("level", int'(lvl), int'(monE.lvl));
               check("press", int'(prs), int'(monE.prs));
               check("release", int'(rel), int'(monE.rel));
               check("repeat", int'(rpt), int'(monE.rpt));
            end
         end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            monE = q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_pulse at cycle %0d: got no pulse, expected press=%b release=%b repeat=%b at cycle %0d",
                     cyc, monE.prs, monE.rel, monE.rpt, monE.cyc);
         end
      end
   end

   initial begin
      int n;
      int r;

      // Reset state
      #1 rstN = 1'b0;
      #2;
      check("reset_level", int'(lvl), 0);
      check("reset_press", int'(prs), 0);
      check("reset_release", int'(rel), 0);
      check("reset_repeat", int'(rpt), 0);
      waitNeg(3);
      rstN  = 1'b1;
      monOn = 1'b1;
      waitNeg(2);

      // Clean press and release of key 0, no repeat
      n = cyc; key[0] = 1'b0;
      push(n + 6, 2'b01, 2'b01, 2'b00, 2'b00);
      waitNeg(12);
      check("held_level", int'(lvl), 1);
      n = cyc; key[0] = 1'b1;
      push(n + 6, 2'b00, 2'b00, 2'b01, 2'b00);
      waitNeg(12);

      // Bounce: toggle every 2 cycles for 20 cycles, end released
      for (int i = 0; i < 10; i++) begin
         key[0] = ~key[0];
         waitNeg(2);
      end
      key[0] = 1'b1;
      waitNeg(10);
      check("bounce_level", int'(lvl), 0);

      // Auto-repeat on key 0; release lands exactly on a would-be repeat edge
      rptEn = 2'b01;
      waitNeg(1);
      n = cyc; key[0] = 1'b0;
      push(n + 6,  2'b01, 2'b01, 2'b00, 2'b00);
      push(n + 16, 2'b01, 2'b00, 2'b00, 2'b01);
      push(n + 19, 2'b01, 2'b00, 2'b00, 2'b01);
      push(n + 22, 2'b01, 2'b00, 2'b00, 2'b01);
      push(n + 25, 2'b00, 2'b00, 2'b01, 2'b00);
      waitNeg(19);
      key[0] = 1'b1;
      waitNeg(20);

      // Simultaneous press; key 1 has repeat disabled
      n = cyc; key = 2'b00;
      push(n + 6,  2'b11, 2'b11, 2'b00, 2'b00);
      push(n + 16, 2'b11, 2'b00, 2'b00, 2'b01);
      push(n + 19, 2'b11, 2'b00, 2'b00, 2'b01);
      push(n + 22, 2'b11, 2'b00, 2'b00, 2'b01);
      push(n + 25, 2'b00, 2'b00, 2'b11, 2'b00);
      waitNeg(19);
      key = 2'b11;
      waitNeg(20);

      // Reset three cycles into key 0 debounce while key 1 is held
      rptEn = 2'b00;
      n = cyc; key[1] = 1'b0;
      push(n + 6, 2'b10, 2'b10, 2'b00, 2'b00);
      waitNeg(8);
      check("pre_reset_level", int'(lvl), 2);
      key[0] = 1'b0;
      waitNeg(3);
      rstN = 1'b0;
      #1;
      check("midreset_level", int'(lvl), 0);
      check("midreset_press", int'(prs), 0);
      check("midreset_release", int'(rel), 0);
      check("midreset_repeat", int'(rpt), 0);
      waitNeg(3);
      rstN = 1'b1;
      r = cyc;
      push(r + 6, 2'b11, 2'b11, 2'b00, 2'b00);
      waitNeg(12);
      n = cyc; key = 2'b11;
      push(n + 6, 2'b00, 2'b00, 2'b11, 2'b00);
      waitNeg(12);

      check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
